counter_share_scheduler: RTL and testbench

Scheduler that time-shares one 8-bit enable counter (ports clk, reset, ena, result) among NREQ requesters. Each requester asks for a run of len counts. The block grants one requester at a time in round-robin order, clears the counter, enables it for exactly len increments, then pulses that requester's done. It sits between the requesting control blocks and the shared counter instance, and drives the counter's reset and ena directly.

---
 rtl/counter_share_scheduler.sv | 127 ++++++++++++
 tb/tb_counter_share_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_share_scheduler.sv
// Round-robin scheduler that time-shares one enable counter among NREQ requesters.
// Each granted run clears the counter, enables it for exactly len counts, then pulses done.
module counter_share_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  input  logic [WIDTH-1:0]        cnt_result,
  output logic                    cnt_reset,
  output logic                    cnt_ena,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    abort,
  output logic                    busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_ptr_nx;
  logic [IW-1:0]    r_own;
  logic [IW-1:0]    w_own_nx;
  logic [IW-1:0]    w_own_inc;
  logic [IW-1:0]    w_win;
  logic [WIDTH-1:0] r_len_q;
  logic [WIDTH-1:0] w_len_nx;
  logic             w_found;
  logic             w_own_req;
  int unsigned      w_idx;

  // Round-robin search starting at r_ptr; first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  assign w_own_inc = (32'(r_own) == NREQ - 1) ? '0 : r_own + IW'(1);
  assign w_own_req = req[r_own];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_len_q <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_own   <= w_own_nx;
      r_len_q <= w_len_nx;
    end
  end

  // Next state and output decode; losing req[own] in CLEAR/RUN aborts the run.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_own_nx   = r_own;
    w_len_nx   = r_len_q;
    cnt_reset  = reset;
    cnt_ena    = 1'b0;
    grant      = '0;
    done       = '0;
    abort      = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_own_nx   = w_win;
          w_len_nx   = len[32'(w_win)*WIDTH +: WIDTH];
          w_state_nx = S_CLEAR;
        end
      end
      S_CLEAR: begin
        grant[r_own] = 1'b1;
        cnt_reset    = 1'b1;
        if (!w_own_req) begin
          abort      = 1'b1;
          w_ptr_nx   = w_own_inc;
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        grant[r_own] = 1'b1;
        if (!w_own_req) begin
          abort      = 1'b1;
          w_ptr_nx   = w_own_inc;
          w_state_nx = S_IDLE;
        end else if (cnt_result == r_len_q) begin
          w_state_nx = S_DONE;
        end else begin
          cnt_ena = 1'b1;
        end
      end
      S_DONE: begin
        grant[r_own] = 1'b1;
        done[r_own]  = 1'b1;
        w_ptr_nx     = w_own_inc;
        w_state_nx   = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_share_scheduler.sv
// Scoreboard bench: stimulus pushes expected done/abort events, a negedge monitor checks them.
module tb_counter_share_scheduler;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clk   = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*WIDTH-1:0] len   = '0;
  logic [WIDTH-1:0]      cnt_result;
  logic                  cnt_reset;
  logic                  cnt_ena;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  abort;
  logic                  busy;

  always #5 clk = ~clk;

  counter_share_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .cnt_result (cnt_result),
    .cnt_reset  (cnt_reset),
    .cnt_ena    (cnt_ena),
    .grant      (grant),
    .done       (done),
    .abort      (abort),
    .busy       (busy)
  );

  // Shared registered enable counter
  always @(posedge clk) begin
    if (cnt_reset)    cnt_result <= '0;
    else if (cnt_ena) cnt_result <= cnt_result + 1'b1;
  end

  int   cyc      = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  typedef struct {
    bit is_abort;
    int idx;
    int lat;
    int ena;
    int res;
    int gstart;
    int gap;
  } exp_t;

  exp_t q[$];
  int   tot = 0;
  int   bad = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    tot++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp_v, cyc);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < int'(NREQ); i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic push(input bit ab, input int idx, input int lat, input int ena,
                      input int res, input int gs, input int gap);
    exp_t e;
    e.is_abort = ab; e.idx = idx; e.lat = lat; e.ena = ena;
    e.res = res; e.gstart = gs; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic set_len(input int idx, input int val);
    len[idx*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_evt(input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done != '0 || abort) && n < maxc);
  endtask

  // Monitor state
  logic [NREQ-1:0] m_prev_grant = '0;
  logic [NREQ-1:0] m_gval = '0;
  bit   m_in_run = 1'b0;
  bit   m_post   = 1'b0;
  int   m_gstart = 0;
  int   m_ena_n  = 0;
  int   m_last_end = -1;
  exp_t m_e;

  always @(negedge clk) begin
    if (reset) chk("cnt_reset_in_reset", int'(cnt_reset), 1);
    if (rst_seen) begin
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ena", int'(cnt_ena), 0);
      chk("rst_done_abort", int'(done) + int'(abort), 0);
    end
    if (reset || rst_seen) begin
      m_in_run = 1'b0;
      m_post   = 1'b0;
    end else begin
      chk("onehot", int'($onehot0(grant) && $onehot0(done) && !(done != '0 && abort)), 1);
      if (m_post) begin
        chk("post_busy", int'(busy), 0);
        chk("post_grant", int'(grant), 0);
        m_post = 1'b0;
      end
      if (grant != '0 && m_prev_grant == '0) begin
        m_gstart = cyc;
        m_gval   = grant;
        m_ena_n  = 0;
        m_in_run = 1'b1;
        chk("clear_cnt_reset", int'(cnt_reset), 1);
        chk("clear_ena", int'(cnt_ena), 0);
      end
      if (m_in_run && cnt_ena) m_ena_n++;
      if (done != '0 || abort) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          m_e = q.pop_front();
          chk("kind_abort", int'(abort), int'(m_e.is_abort));
          chk("owner", idx_of(m_gval), m_e.idx);
          if (!m_e.is_abort) chk("done_idx", idx_of(done), m_e.idx);
          chk("grant_held", int'(grant), int'(m_gval));
          chk("latency", cyc - m_gstart, m_e.lat);
          chk("ena_cycles", m_ena_n, m_e.ena);
          chk("cnt_result", int'(cnt_result), m_e.res);
          if (m_e.gstart >= 0) chk("grant_cycle", m_gstart, m_e.gstart);
          if (m_e.gap >= 0)    chk("gap", m_gstart - m_last_end, m_e.gap);
        end
        m_last_end = cyc;
        m_post     = 1'b1;
        m_in_run   = 1'b0;
      end
    end
    m_prev_grant = grant;
    if (stim_done || cyc > 40000) begin
      chk("queue_empty", q.size(), 0);
      chk("watchdog", int'(cyc > 40000), 0);
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
    end
  end

  initial begin
    int n;
    idle(2);
    reset = 1'b0;

    // Single request, len 5
    set_len(0, 5);
    req = 4'b0001;
    push(1'b0, 0, 7, 5, 5, cyc + 1, -1);
    wait_evt(40);
    idle(1);
    req = '0;
    idle(1);

    // Zero length on requester 2
    set_len(2, 0);
    req = 4'b0100;
    push(1'b0, 2, 2, 0, 0, cyc + 1, -1);
    wait_evt(40);
    idle(1);
    req = '0;
    idle(1);

    // Round robin from a freshly reset pointer, all len 3
    reset = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) set_len(i, 3);
    req = 4'b1111;
    idle(2);
    reset = 1'b0;
    push(1'b0, 0, 5, 3, 3, cyc + 1, -1);
    push(1'b0, 1, 5, 3, 3, -1, 2);
    push(1'b0, 2, 5, 3, 3, -1, 2);
    push(1'b0, 3, 5, 3, 3, -1, 2);
    push(1'b0, 0, 5, 3, 3, -1, 2);
    repeat (5) wait_evt(40);
    idle(1);
    req = '0;
    idle(1);

    // Abort: requester 1 drops in its 4th RUN cycle, requester 2 pending
    set_len(1, 10);
    set_len(2, 1);
    req = 4'b0110;
    push(1'b1, 1, 4, 3, 3, cyc + 1, -1);
    push(1'b0, 2, 3, 1, 1, -1, 2);
    idle(5);
    req[1] = 1'b0;
    wait_evt(40);
    wait_evt(40);
    idle(1);
    req = '0;
    idle(1);

    // Reset mid-run at count 50, then requesters 0 and 3 after reset
    set_len(3, 200);
    req = 4'b1000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cnt_result != 8'd50 && n < 300);
    idle(1);
    reset = 1'b1;
    req   = 4'b1001;
    set_len(3, 2);
    set_len(0, 4);
    idle(2);
    reset = 1'b0;
    push(1'b0, 0, 6, 4, 4, cyc + 1, -1);
    push(1'b0, 3, 4, 2, 2, -1, 2);
    wait_evt(40);
    wait_evt(40);
    idle(1);
    req = '0;
    idle(1);

    // Maximum length, counter must stop at 255
    set_len(0, 255);
    req = 4'b0001;
    push(1'b0, 0, 257, 255, 255, cyc + 1, -1);
    wait_evt(400);
    idle(1);
    req = '0;
    idle(3);
    stim_done = 1'b1;
  end

endmodule
